// File: rtl/window_write_ctrl.sv
// rtl/window_write_ctrl.sv - SPARC register-window write-back controller
// Tracks CWP/WIM, maps rd onto a physical register, and handles SAVE/RESTORE with window traps.
module window_write_ctrl #(
  parameter int NWINDOWS = 8,
  parameter int CWP_W    = 3,
  localparam int NREGS   = 8 + 16*NWINDOWS
) (
  input  logic                Clk,
  input  logic                Clr,
  input  logic                wr_req,
  input  logic [4:0]          rd_addr,
  input  logic [31:0]         wdata,
  input  logic                save,
  input  logic                restore,
  input  logic                cwp_we,
  input  logic [CWP_W-1:0]    cwp_in,
  input  logic                wim_we,
  input  logic [NWINDOWS-1:0] wim_in,
  input  logic                trap_ack,
  output logic [NREGS-1:0]    loadE_n,
  output logic [31:0]         wdata_q,
  output logic [CWP_W-1:0]    cwp,
  output logic [NWINDOWS-1:0] wim,
  output logic                trap_pending,
  output logic [1:0]          trap_type,
  output logic                illegal_cwp
);

  localparam int               IDX_W   = $clog2(NREGS);
  localparam logic [CWP_W-1:0] CWP_MAX = CWP_W'(NWINDOWS - 1);
  localparam logic [CWP_W:0]   NW_LIM  = (CWP_W+1)'(NWINDOWS);

  typedef enum logic {RUN, TRAP} state_t;

  state_t               state, state_nxt;
  logic [CWP_W-1:0]     cwp_dec, cwp_inc, cwp_nxt;
  logic                 wim_dec_bit, wim_inc_bit;
  logic                 illegal_nxt, trap_go;
  logic [1:0]           trap_go_type;
  logic [IDX_W-1:0]     phys;
  logic [NREGS-1:0]     load_nxt;

  // Window neighbours with modulo-NWINDOWS wrap
  always_comb begin
    cwp_dec     = (cwp == '0) ? CWP_MAX : cwp - 1'b1;
    cwp_inc     = (cwp == CWP_MAX) ? '0 : cwp + 1'b1;
    wim_dec_bit = |(wim & (NWINDOWS'(1) << cwp_dec));
    wim_inc_bit = |(wim & (NWINDOWS'(1) << cwp_inc));
  end

  always_comb begin
    cwp_nxt      = cwp;
    illegal_nxt  = 1'b0;
    trap_go      = 1'b0;
    trap_go_type = 2'b00;
    if (cwp_we) begin
      if ({1'b0, cwp_in} < NW_LIM) cwp_nxt = cwp_in;
      else                         illegal_nxt = 1'b1;
    end else if (state == RUN && (save ^ restore)) begin
      if (save) begin
        if (wim_dec_bit) begin
          trap_go      = 1'b1;
          trap_go_type = 2'b01;
        end else begin
          cwp_nxt = cwp_dec;
        end
      end else begin
        if (wim_inc_bit) begin
          trap_go      = 1'b1;
          trap_go_type = 2'b10;
        end else begin
          cwp_nxt = cwp_inc;
        end
      end
    end
  end

  // Ins alias the outs of the next window up (the caller's outs)
  always_comb begin
    phys     = '0;
    load_nxt = '1;
    case (rd_addr[4:3])
      2'b00:   phys = IDX_W'(rd_addr);
      2'b01:   phys = IDX_W'(8  + 16*int'(cwp)     + int'(rd_addr[2:0]));
      2'b10:   phys = IDX_W'(16 + 16*int'(cwp)     + int'(rd_addr[2:0]));
      default: phys = IDX_W'(8  + 16*int'(cwp_inc) + int'(rd_addr[2:0]));
    endcase
    if (wr_req && rd_addr != 5'd0) load_nxt = ~(NREGS'(1) << phys);
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (trap_go)  state_nxt = TRAP;
      TRAP:    if (trap_ack) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    trap_pending = (state == TRAP);
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      loadE_n     <= '1;
      wdata_q     <= '0;
      cwp         <= '0;
      wim         <= '0;
      trap_type   <= 2'b00;
      illegal_cwp <= 1'b0;
    end else begin
      loadE_n     <= load_nxt;
      cwp         <= cwp_nxt;
      illegal_cwp <= illegal_nxt;
      if (wr_req) wdata_q <= wdata;
      if (wim_we) wim <= wim_in;
      if (state == RUN && trap_go)        trap_type <= trap_go_type;
      else if (state == TRAP && trap_ack) trap_type <= 2'b00;
    end
  end

endmodule
